// File: rtl/if_id_pipe_ctrl_pkg.sv
// rtl/if_id_pipe_ctrl_pkg.sv - shared encodings for the IF/ID front-end pipeline control
package if_id_pipe_ctrl_pkg;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

    // Front-end state as seen by debug
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } pipe_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Flush outranks stall; anything else is a normal run cycle
    function automatic pipe_state_t next_state(input logic if_flush, input logic pc_write);
        if (if_flush)
            return ST_FLUSH;
        else if (!pc_write)
            return ST_STALL;
        else
            return ST_RUN;
    endfunction

endpackage

// File: rtl/if_id_pipe_ctrl_if.sv
// rtl/if_id_pipe_ctrl_if.sv - hazard requests, fetch/decode data and debug outputs of the front end
interface if_id_pipe_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
);
    // Hazard-unit requests and fetch/decode inputs
    logic              pc_write;
    logic              if_id_write;
    logic              if_flush;
    logic              bubble_sel;
    logic [1:0]        pc_src;
    logic [DATA_W-1:0] branch_target;
    logic [DATA_W-1:0] jump_target;
    logic [DATA_W-1:0] imem_instr;
    logic [CTRL_W-1:0] id_ctrl_in;

    // Pipeline and debug outputs
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] if_id_instr;
    logic [DATA_W-1:0] if_id_pc4;
    logic              if_id_valid;
    logic [CTRL_W-1:0] id_ctrl_out;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              stall_timeout;

    modport master (
        output pc_write, if_id_write, if_flush, bubble_sel, pc_src,
               branch_target, jump_target, imem_instr, id_ctrl_in,
        input  pc, if_id_instr, if_id_pc4, if_id_valid, id_ctrl_out,
               state, stall_cnt, flush_cnt, stall_timeout
    );

    modport slave (
        input  pc_write, if_id_write, if_flush, bubble_sel, pc_src,
               branch_target, jump_target, imem_instr, id_ctrl_in,
        output pc, if_id_instr, if_id_pc4, if_id_valid, id_ctrl_out,
               state, stall_cnt, flush_cnt, stall_timeout
    );

endinterface

// File: rtl/if_id_pipe_ctrl_pc_next_sel.sv
// rtl/if_id_pipe_ctrl_pc_next_sel.sv - combinational next-PC mux over pc_src and pc_write
module if_id_pipe_ctrl_pc_next_sel
    import if_id_pipe_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] pc,
    input  logic              pc_write,
    input  logic [1:0]        pc_src,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] jump_target,
    output logic [DATA_W-1:0] pc_plus4,
    output logic [DATA_W-1:0] pc_next
);

    // Sequential fetch address, wraps modulo 2^DATA_W
    assign pc_plus4 = pc + DATA_W'(4);

    // A stall freezes the PC regardless of pc_src; the reserved encoding also holds
    always_comb begin
        pc_next = pc;
        if (pc_write) begin
            case (pc_src)
                PC_SRC_SEQ:    pc_next = pc_plus4;
                PC_SRC_BRANCH: pc_next = branch_target;
                PC_SRC_JUMP:   pc_next = jump_target;
                default:       pc_next = pc;
            endcase
        end
    end

endmodule

// File: rtl/if_id_pipe_ctrl.sv
// rtl/if_id_pipe_ctrl.sv - PC register, IF/ID register, ID/EX bubble mux, event counters and stall watchdog
module if_id_pipe_ctrl
    import if_id_pipe_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 10,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT),
    parameter int                CNT_W     = 16,
    parameter int                MAX_STALL = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    if_id_pipe_ctrl_if.slave bus
);

    // Run counter only needs to reach MAX_STALL; it parks there afterwards
    localparam int               RUN_W    = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc4_q;
    logic              valid_q;
    pipe_state_t       state_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [RUN_W-1:0]  run_q;
    logic              timeout_q;

    if_id_pipe_ctrl_pc_next_sel #(
        .DATA_W (DATA_W)
    ) u_pc_next_sel (
        .pc            (pc_q),
        .pc_write      (bus.pc_write),
        .pc_src        (bus.pc_src),
        .branch_target (bus.branch_target),
        .jump_target   (bus.jump_target),
        .pc_plus4      (pc_plus4),
        .pc_next       (pc_next)
    );

    // PC register; the hold case is folded into pc_next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_next;
    end

    // IF/ID register: flush beats hold beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.if_flush) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (bus.if_id_write) begin
            instr_q <= bus.imem_instr;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    // Debug FSM: state reflects the request sampled on the previous edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_RUN;
        else
            state_q <= next_state(bus.if_flush, bus.pc_write);
    end

    // Saturating stall/flush event counters; both may step in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!bus.pc_write && stall_cnt_q != CNT_SAT)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (bus.if_flush && flush_cnt_q != CNT_SAT)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    // Watchdog: timeout latches on the edge that completes MAX_STALL consecutive stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else if (bus.pc_write) begin
            run_q <= '0;
        end else begin
            if (run_q != RUN_MAX)
                run_q <= run_q + 1'b1;
            if (run_q == RUN_LAST)
                timeout_q <= 1'b1;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.if_id_instr   = instr_q;
    assign bus.if_id_pc4     = pc4_q;
    assign bus.if_id_valid   = valid_q;
    assign bus.state         = state_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
    assign bus.stall_timeout = timeout_q;

    // Control bubble into ID/EX is zero-latency
    assign bus.id_ctrl_out = bus.bubble_sel ? {CTRL_W{1'b0}} : bus.id_ctrl_in;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// tb/tb_if_id_pipe_ctrl.sv - directed self-checking bench for if_id_pipe_ctrl
module tb_if_id_pipe_ctrl;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 4;
    localparam logic [31:0] IMEM_TAG = 32'hA000_0000;
    localparam logic [9:0]  CTRL_VAL = 10'h2A5;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    if_id_pipe_ctrl_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    if_id_pipe_ctrl #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .RESET_PC  (32'h0),
        .NOP_INSTR (32'h0),
        .CNT_W     (CNT_W),
        .MAX_STALL (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Combinational instruction memory: word at address p is IMEM_TAG | p
    assign bus.imem_instr = IMEM_TAG | bus.pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"},      bus.pc,            32'h0);
        check({tag, " instr"},   bus.if_id_instr,   32'h0);
        check({tag, " pc4"},     bus.if_id_pc4,     32'h0);
        check({tag, " valid"},   {31'b0, bus.if_id_valid},   32'h0);
        check({tag, " state"},   {30'b0, bus.state},         32'h0);
        check({tag, " stall"},   {28'b0, bus.stall_cnt},     32'h0);
        check({tag, " flush"},   {28'b0, bus.flush_cnt},     32'h0);
        check({tag, " timeout"}, {31'b0, bus.stall_timeout}, 32'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n             = 1'b0;
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.if_flush      = 1'b0;
        bus.bubble_sel    = 1'b0;
        bus.pc_src        = 2'b00;
        bus.branch_target = 32'h0;
        bus.jump_target   = 32'h0;
        bus.id_ctrl_in    = CTRL_VAL;

        #12;
        check_reset_state("rst");
        check("rst ctrl", {22'b0, bus.id_ctrl_out}, {22'b0, CTRL_VAL});
        rst_n = 1'b1;

        // Free run: pc 4,8,12,16; IF/ID carries the previous fetch
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run pc",    bus.pc,          32'(4 * k));
            check("run pc4",   bus.if_id_pc4,   32'(4 * k));
            check("run instr", bus.if_id_instr, IMEM_TAG | 32'(4 * (k - 1)));
            check("run valid", {31'b0, bus.if_id_valid}, 32'h1);
        end

        // Async reset pulse mid-run
        #3 rst_n = 1'b0;
        #1 check_reset_state("arst1");
        rst_n = 1'b1;
        tick();
        tick();
        check("rerun pc", bus.pc, 32'h8);

        // Load-use stall at pc=8
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.bubble_sel  = 1'b1;
        #1 check("bubble ctrl", {22'b0, bus.id_ctrl_out}, 32'h0);
        tick();
        check("stall pc",    bus.pc,          32'h8);
        check("stall instr", bus.if_id_instr, IMEM_TAG | 32'h4);
        check("stall pc4",   bus.if_id_pc4,   32'h8);
        check("stall state", {30'b0, bus.state},     32'h1);
        check("stall cnt",   {28'b0, bus.stall_cnt}, 32'h1);

        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.bubble_sel  = 1'b0;
        #1 check("unbubble ctrl", {22'b0, bus.id_ctrl_out}, {22'b0, CTRL_VAL});
        tick();
        check("resume pc",    bus.pc,          32'hC);
        check("resume instr", bus.if_id_instr, IMEM_TAG | 32'h8);
        check("resume state", {30'b0, bus.state}, 32'h0);

        // Taken branch at pc=12
        bus.pc_src        = 2'b01;
        bus.branch_target = 32'h40;
        bus.if_flush      = 1'b1;
        tick();
        check("br pc",    bus.pc,          32'h40);
        check("br instr", bus.if_id_instr, 32'h0);
        check("br pc4",   bus.if_id_pc4,   32'h0);
        check("br valid", {31'b0, bus.if_id_valid}, 32'h0);
        check("br state", {30'b0, bus.state},       32'h2);
        check("br flush", {28'b0, bus.flush_cnt},   32'h1);

        bus.pc_src   = 2'b00;
        bus.if_flush = 1'b0;
        tick();
        check("post br pc",    bus.pc,          32'h44);
        check("post br instr", bus.if_id_instr, IMEM_TAG | 32'h40);
        check("post br state", {30'b0, bus.state}, 32'h0);

        // Flush overrides IF/ID hold
        bus.if_flush    = 1'b1;
        bus.if_id_write = 1'b0;
        tick();
        check("fh pc",    bus.pc,          32'h48);
        check("fh instr", bus.if_id_instr, 32'h0);
        check("fh valid", {31'b0, bus.if_id_valid}, 32'h0);
        check("fh flush", {28'b0, bus.flush_cnt},   32'h2);

        // Reserved pc_src holds the PC
        bus.if_flush    = 1'b0;
        bus.if_id_write = 1'b1;
        bus.pc_src      = 2'b11;
        tick();
        check("rsv pc",    bus.pc,          32'h48);
        check("rsv instr", bus.if_id_instr, IMEM_TAG | 32'h48);

        // Jump
        bus.pc_src      = 2'b10;
        bus.jump_target = 32'h100;
        tick();
        check("jmp pc", bus.pc, 32'h100);

        // Watchdog: 8 consecutive stalls
        bus.pc_src      = 2'b00;
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7)
                check("wd 7th", {31'b0, bus.stall_timeout}, 32'h0);
        end
        check("wd 8th",   {31'b0, bus.stall_timeout}, 32'h1);
        check("wd pc",    bus.pc, 32'h100);
        check("wd stall", {28'b0, bus.stall_cnt}, 32'h9);

        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        tick();
        check("wd sticky", {31'b0, bus.stall_timeout}, 32'h1);
        check("wd pc run", bus.pc, 32'h104);

        // Stall and flush in the same cycle: both counters step, flush state wins
        bus.pc_write = 1'b0;
        bus.if_flush = 1'b1;
        tick();
        check("sf pc",    bus.pc, 32'h104);
        check("sf state", {30'b0, bus.state},     32'h2);
        check("sf stall", {28'b0, bus.stall_cnt}, 32'hA);
        check("sf flush", {28'b0, bus.flush_cnt}, 32'h3);

        // Stall counter saturates at all-ones
        bus.if_flush = 1'b0;
        for (int i = 0; i < 6; i++)
            tick();
        check("sat stall", {28'b0, bus.stall_cnt}, 32'hF);
        check("sat state", {30'b0, bus.state},     32'h1);

        // Async reset mid-stall, then fetch restarts at 0
        #3 rst_n = 1'b0;
        #1 check_reset_state("arst2");
        rst_n        = 1'b1;
        bus.pc_write = 1'b1;
        tick();
        check("restart pc",    bus.pc,          32'h4);
        check("restart instr", bus.if_id_instr, IMEM_TAG);
        check("restart valid", {31'b0, bus.if_id_valid}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
